// File: rtl/reexe_multi_fwd.sv
// ----------------------------------------------------------------------------
// reexe_multi_fwd
//   Delayed-execution stage between SBA and MEM. It holds one instruction and
//   re-runs a single-cycle ALU op on operands that are resolved late. Each
//   operand may come from:
//     source 0            latched regfile read data
//     source 1            this stage's own last retired result
//     sources 2..SRC_NUM-1  late write-back buses (lateFwd_i)
//   The late buses are only valid in the first held cycle. They are captured
//   at the end of that cycle, so a stalled instruction keeps stable operands.
//   The result is combinational from the latched state (latency 1).
//
// Ports
//   clk, rst                   clock, asynchronous active-high reset
//   flush_i                    kill held instruction and pending captures
//   in_valid_i / in_allowin_o  upstream handshake
//   out_valid_o / out_allowin_i  downstream (MEM) handshake
//   in_*                       instruction payload latched on acceptance
//   lateFwd_i                  late forward buses, SRC_NUM-2 of them
//   fwd_valid_o, fwd_num_o     forward port towards the earlier stages
//   out_writeNum_o, out_pc_o   registered destination and PC
//   out_data_o, out_ovf_o      final result and overflow trap
// ----------------------------------------------------------------------------
module reexe_multi_fwd #(
  parameter int DATA_W  = 32,
  parameter int REG_W   = 5,
  parameter int SRC_NUM = 4,
  parameter int OP_W    = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          flush_i,
  input  logic                          in_valid_i,
  output logic                          in_allowin_o,
  input  logic                          out_allowin_i,
  output logic                          out_valid_o,
  input  logic [REG_W-1:0]              in_writeNum_i,
  input  logic [DATA_W-1:0]             in_pc_i,
  input  logic                          in_notExc_i,
  input  logic [DATA_W-1:0]             in_preRes_i,
  input  logic [OP_W-1:0]               in_aluOp_i,
  input  logic                          in_trapOvf_i,
  input  logic [1:0]                    in_opIsReg_i,
  input  logic [2*DATA_W-1:0]           in_preSrc_i,
  input  logic [2*DATA_W-1:0]           in_readData_i,
  input  logic [2*SRC_NUM-1:0]          in_fwdSel_i,
  input  logic [(SRC_NUM-2)*DATA_W-1:0] lateFwd_i,
  output logic                          fwd_valid_o,
  output logic [REG_W-1:0]              fwd_num_o,
  output logic [REG_W-1:0]              out_writeNum_o,
  output logic [DATA_W-1:0]             out_pc_o,
  output logic [DATA_W-1:0]             out_data_o,
  output logic                          out_ovf_o
);

  localparam int SH_W = $clog2(DATA_W);

  localparam logic [OP_W-1:0] OP_ADD  = OP_W'(0);
  localparam logic [OP_W-1:0] OP_SUB  = OP_W'(1);
  localparam logic [OP_W-1:0] OP_AND  = OP_W'(2);
  localparam logic [OP_W-1:0] OP_OR   = OP_W'(3);
  localparam logic [OP_W-1:0] OP_XOR  = OP_W'(4);
  localparam logic [OP_W-1:0] OP_NOR  = OP_W'(5);
  localparam logic [OP_W-1:0] OP_SLT  = OP_W'(6);
  localparam logic [OP_W-1:0] OP_SLTU = OP_W'(7);
  localparam logic [OP_W-1:0] OP_SLL  = OP_W'(8);
  localparam logic [OP_W-1:0] OP_SRL  = OP_W'(9);
  localparam logic [OP_W-1:0] OP_SRA  = OP_W'(10);
  localparam logic [OP_W-1:0] OP_LUI  = OP_W'(11);

  // Held instruction
  logic                 r_has;
  logic [REG_W-1:0]     r_wnum;
  logic [DATA_W-1:0]    r_pc;
  logic                 r_notExc;
  logic [DATA_W-1:0]    r_preRes;
  logic [OP_W-1:0]      r_op;
  logic                 r_trap;
  logic [1:0]           r_isReg;
  logic [2*DATA_W-1:0]  r_preSrc;
  logic [2*DATA_W-1:0]  r_rdata;
  logic [2*SRC_NUM-1:0] r_sel;

  // Late-capture state, one slot per operand
  logic [1:0]           r_saved;
  logic [2*DATA_W-1:0]  r_cap;

  // Own last retired result (source 1)
  logic [DATA_W-1:0]    r_last;

  logic                 w_in_allow;
  logic                 w_in_fire;
  logic                 w_out_fire;
  logic [2*DATA_W-1:0]  w_live;
  logic [2*DATA_W-1:0]  w_opnd;
  logic [DATA_W-1:0]    w_a;
  logic [DATA_W-1:0]    w_b;
  logic [DATA_W-1:0]    w_sum;
  logic [DATA_W-1:0]    w_diff;
  logic [SH_W-1:0]      w_sh;
  logic [DATA_W-1:0]    w_alu;
  logic                 w_ovf_raw;
  logic [DATA_W-1:0]    w_data;

  assign w_in_allow = !r_has | out_allowin_i;
  assign w_out_fire = r_has & out_allowin_i;
  assign w_in_fire  = in_valid_i & w_in_allow;

  // Operand resolution. The late part of a register operand is taken live
  // from the buses until the capture slot is filled, then from the slot.
  for (genvar g = 0; g < 2; g++) begin : g_opnd
    logic [SRC_NUM-1:0] w_sel;
    logic [DATA_W-1:0]  w_late_live;
    logic [DATA_W-1:0]  w_reg;

    assign w_sel = r_sel[g*SRC_NUM +: SRC_NUM];

    always_comb begin
      w_late_live = '0;
      for (int k = 2; k < SRC_NUM; k++) begin
        if (w_sel[k]) w_late_live = w_late_live | lateFwd_i[(k-2)*DATA_W +: DATA_W];
      end
    end

    // OR-combine keeps an all-zero select at 0 and a multi-hot select bounded.
    assign w_reg = ({DATA_W{w_sel[0]}} & r_rdata[g*DATA_W +: DATA_W])
                 | ({DATA_W{w_sel[1]}} & r_last)
                 | (r_saved[g] ? r_cap[g*DATA_W +: DATA_W] : w_late_live);

    assign w_live[g*DATA_W +: DATA_W] = w_late_live;
    assign w_opnd[g*DATA_W +: DATA_W] = r_isReg[g] ? w_reg : r_preSrc[g*DATA_W +: DATA_W];
  end

  assign w_a    = w_opnd[DATA_W-1:0];
  assign w_b    = w_opnd[2*DATA_W-1:DATA_W];
  assign w_sum  = w_a + w_b;
  assign w_diff = w_a - w_b;
  assign w_sh   = w_a[SH_W-1:0];

  always_comb begin
    w_alu     = '0;
    w_ovf_raw = 1'b0;
    case (r_op)
      OP_ADD: begin
        w_alu     = w_sum;
        w_ovf_raw = (w_a[DATA_W-1] == w_b[DATA_W-1]) && (w_sum[DATA_W-1] != w_a[DATA_W-1]);
      end
      OP_SUB: begin
        w_alu     = w_diff;
        w_ovf_raw = (w_a[DATA_W-1] != w_b[DATA_W-1]) && (w_diff[DATA_W-1] != w_a[DATA_W-1]);
      end
      OP_AND:  w_alu = w_a & w_b;
      OP_OR:   w_alu = w_a | w_b;
      OP_XOR:  w_alu = w_a ^ w_b;
      OP_NOR:  w_alu = ~(w_a | w_b);
      OP_SLT:  w_alu = {{(DATA_W-1){1'b0}}, ($signed(w_a) < $signed(w_b))};
      OP_SLTU: w_alu = {{(DATA_W-1){1'b0}}, (w_a < w_b)};
      OP_SLL:  w_alu = w_b << w_sh;
      OP_SRL:  w_alu = w_b >> w_sh;
      OP_SRA:  w_alu = $unsigned($signed(w_b) >>> w_sh);
      OP_LUI:  w_alu = w_b << 16;
      default: w_alu = '0;
    endcase
  end

  assign w_data = r_notExc ? w_alu : r_preRes;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_has    <= 1'b0;
      r_wnum   <= '0;
      r_pc     <= '0;
      r_notExc <= 1'b0;
      r_preRes <= '0;
      r_op     <= '0;
      r_trap   <= 1'b0;
      r_isReg  <= '0;
      r_preSrc <= '0;
      r_rdata  <= '0;
      r_sel    <= '0;
      r_saved  <= '0;
      r_cap    <= '0;
      r_last   <= '0;
    end else begin
      // Every retirement updates source 1, flush does not clear it.
      if (w_out_fire) r_last <= w_data;

      if (flush_i) begin
        r_has   <= 1'b0;
        r_saved <= '0;
      end else if (w_in_fire) begin
        r_has    <= 1'b1;
        r_wnum   <= in_writeNum_i;
        r_pc     <= in_pc_i;
        r_notExc <= in_notExc_i;
        r_preRes <= in_preRes_i;
        r_op     <= in_aluOp_i;
        r_trap   <= in_trapOvf_i;
        r_isReg  <= in_opIsReg_i;
        r_preSrc <= in_preSrc_i;
        r_rdata  <= in_readData_i;
        r_sel    <= in_fwdSel_i;
        r_saved  <= '0;
      end else if (w_out_fire) begin
        r_has <= 1'b0;
      end else if (r_has) begin
        // First held cycle: freeze whatever the late buses carry now.
        for (int j = 0; j < 2; j++) begin
          if (!r_saved[j]) begin
            r_cap[j*DATA_W +: DATA_W] <= w_live[j*DATA_W +: DATA_W];
            r_saved[j]                <= 1'b1;
          end
        end
      end
    end
  end

  assign in_allowin_o   = w_in_allow;
  assign out_valid_o    = r_has;
  assign fwd_valid_o    = r_has;
  assign fwd_num_o      = r_has ? r_wnum : '0;
  assign out_writeNum_o = r_wnum;
  assign out_pc_o       = r_pc;
  assign out_data_o     = w_data;
  assign out_ovf_o      = r_has & r_notExc & r_trap & w_ovf_raw;

endmodule

// File: tb/tb_reexe_multi_fwd.sv
// ----------------------------------------------------------------------------
// tb_reexe_multi_fwd
//   Directed cases with literal expectations, then randomized traffic checked
//   every cycle against a transaction-level model of the stage.
// ----------------------------------------------------------------------------
module tb_reexe_multi_fwd;

  localparam int DW = 32;
  localparam int RW = 5;
  localparam int SN = 4;
  localparam int OW = 4;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            flush_i;
  logic            in_valid_i;
  logic            in_allowin_o;
  logic            out_allowin_i;
  logic            out_valid_o;
  logic [RW-1:0]   in_writeNum_i;
  logic [DW-1:0]   in_pc_i;
  logic            in_notExc_i;
  logic [DW-1:0]   in_preRes_i;
  logic [OW-1:0]   in_aluOp_i;
  logic            in_trapOvf_i;
  logic [1:0]      in_opIsReg_i;
  logic [2*DW-1:0] in_preSrc_i;
  logic [2*DW-1:0] in_readData_i;
  logic [2*SN-1:0] in_fwdSel_i;
  logic [(SN-2)*DW-1:0] lateFwd_i;
  logic            fwd_valid_o;
  logic [RW-1:0]   fwd_num_o;
  logic [RW-1:0]   out_writeNum_o;
  logic [DW-1:0]   out_pc_o;
  logic [DW-1:0]   out_data_o;
  logic            out_ovf_o;

  reexe_multi_fwd #(.DATA_W(DW), .REG_W(RW), .SRC_NUM(SN), .OP_W(OW)) dut (
    .clk(clk), .rst(rst), .flush_i(flush_i),
    .in_valid_i(in_valid_i), .in_allowin_o(in_allowin_o),
    .out_allowin_i(out_allowin_i), .out_valid_o(out_valid_o),
    .in_writeNum_i(in_writeNum_i), .in_pc_i(in_pc_i), .in_notExc_i(in_notExc_i),
    .in_preRes_i(in_preRes_i), .in_aluOp_i(in_aluOp_i), .in_trapOvf_i(in_trapOvf_i),
    .in_opIsReg_i(in_opIsReg_i), .in_preSrc_i(in_preSrc_i), .in_readData_i(in_readData_i),
    .in_fwdSel_i(in_fwdSel_i), .lateFwd_i(lateFwd_i),
    .fwd_valid_o(fwd_valid_o), .fwd_num_o(fwd_num_o),
    .out_writeNum_o(out_writeNum_o), .out_pc_o(out_pc_o),
    .out_data_o(out_data_o), .out_ovf_o(out_ovf_o)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  typedef struct packed {
    logic [4:0]  wnum;
    logic [31:0] pc;
    logic        notExc;
    logic [31:0] preRes;
    logic [3:0]  op;
    logic        trap;
    logic [1:0]  isReg;
    logic [63:0] pre;
    logic [63:0] rd;
    logic [7:0]  sel;
  } ins_t;

  ins_t        m_ins;
  bit          m_has;
  bit          m_saved;
  logic [31:0] m_last;
  logic [63:0] m_snap;  // late buses as seen in the first held cycle

  function automatic logic [31:0] m_operand(input int j);
    logic [3:0]  s;
    logic [31:0] v;
    logic [63:0] buses;
    if (!m_ins.isReg[j]) return m_ins.pre[j*32 +: 32];
    s     = m_ins.sel[j*4 +: 4];
    buses = m_saved ? m_snap : lateFwd_i;
    v     = 32'h0;
    if (s[0]) v = v | m_ins.rd[j*32 +: 32];
    if (s[1]) v = v | m_last;
    if (s[2]) v = v | buses[31:0];
    if (s[3]) v = v | buses[63:32];
    return v;
  endfunction

  function automatic logic [31:0] m_alu(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    case (op)
      4'd0:  return a + b;
      4'd1:  return a - b;
      4'd2:  return a & b;
      4'd3:  return a | b;
      4'd4:  return a ^ b;
      4'd5:  return ~(a | b);
      4'd6:  return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      4'd7:  return (a < b) ? 32'd1 : 32'd0;
      4'd8:  return b << a[4:0];
      4'd9:  return b >> a[4:0];
      4'd10: return $unsigned($signed(b) >>> a[4:0]);
      4'd11: return {b[15:0], 16'h0};
      default: return 32'h0;
    endcase
  endfunction

  // Overflow from exact integer arithmetic: result outside the 32-bit signed range.
  function automatic bit m_ovf(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, r;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    if (op == 4'd0)      r = sa + sb;
    else if (op == 4'd1) r = sa - sb;
    else return 1'b0;
    return (r > 64'sd2147483647) || (r < -64'sd2147483648);
  endfunction

  function automatic logic [31:0] m_result();
    return m_ins.notExc ? m_alu(m_ins.op, m_operand(0), m_operand(1)) : m_ins.preRes;
  endfunction

  function automatic bit m_trap();
    return m_has && m_ins.notExc && m_ins.trap && m_ovf(m_ins.op, m_operand(0), m_operand(1));
  endfunction

  task automatic model_reset();
    m_has   = 1'b0;
    m_saved = 1'b0;
    m_last  = 32'h0;
    m_snap  = 64'h0;
    m_ins   = '0;
  endtask

  task automatic model_check();
    chk("in_allowin", 32'(in_allowin_o), 32'(!m_has || out_allowin_i));
    chk("out_valid", 32'(out_valid_o), 32'(m_has));
    chk("fwd_valid", 32'(fwd_valid_o), 32'(m_has));
    chk("fwd_num", 32'(fwd_num_o), m_has ? 32'(m_ins.wnum) : 32'h0);
    chk("out_ovf", 32'(out_ovf_o), 32'(m_trap()));
    if (m_has) begin
      chk("out_data", out_data_o, m_result());
      chk("out_pc", out_pc_o, m_ins.pc);
      chk("out_writeNum", 32'(out_writeNum_o), 32'(m_ins.wnum));
    end
  endtask

  task automatic model_update();
    bit          outfire, infire;
    logic [31:0] res;
    if (rst) begin
      model_reset();
      return;
    end
    res     = m_result();
    outfire = m_has && out_allowin_i;
    infire  = in_valid_i && (!m_has || out_allowin_i);
    if (outfire) m_last = res;
    if (flush_i) begin
      m_has   = 1'b0;
      m_saved = 1'b0;
    end else if (infire) begin
      m_ins.wnum   = in_writeNum_i;
      m_ins.pc     = in_pc_i;
      m_ins.notExc = in_notExc_i;
      m_ins.preRes = in_preRes_i;
      m_ins.op     = in_aluOp_i;
      m_ins.trap   = in_trapOvf_i;
      m_ins.isReg  = in_opIsReg_i;
      m_ins.pre    = in_preSrc_i;
      m_ins.rd     = in_readData_i;
      m_ins.sel    = in_fwdSel_i;
      m_has        = 1'b1;
      m_saved      = 1'b0;
    end else if (outfire) begin
      m_has = 1'b0;
    end else if (m_has && !m_saved) begin
      m_snap  = lateFwd_i;
      m_saved = 1'b1;
    end
  endtask

  // Inputs change 1 time unit after posedge; outputs are checked on negedge.
  task automatic sample();
    @(negedge clk);
    if (rst) model_reset();
    model_check();
  endtask

  task automatic advance();
    model_update();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    flush_i       = 1'b0;
    in_valid_i    = 1'b0;
    out_allowin_i = 1'b1;
    in_writeNum_i = '0;
    in_pc_i       = '0;
    in_notExc_i   = 1'b1;
    in_preRes_i   = '0;
    in_aluOp_i    = '0;
    in_trapOvf_i  = 1'b0;
    in_opIsReg_i  = '0;
    in_preSrc_i   = '0;
    in_readData_i = '0;
    in_fwdSel_i   = '0;
    lateFwd_i     = '0;
  endtask

  function automatic logic [31:0] rval();
    case ($urandom_range(0, 5))
      0: return 32'h7FFF_FFFF;
      1: return 32'h8000_0000;
      2: return 32'($urandom_range(0, 40));
      3: return 32'hFFFF_FFFF;
      default: return 32'($urandom);
    endcase
  endfunction

  function automatic logic [3:0] rsel();
    int r;
    r = $urandom_range(0, 4);
    return (r == 4) ? 4'b0000 : 4'(1 << r);
  endfunction

  initial begin
    idle_inputs();
    rst = 1'b1;
    model_reset();
    @(posedge clk);
    #1;

    // Reset state
    sample();
    chk("rst_out_valid", 32'(out_valid_o), 32'h0);
    chk("rst_in_allowin", 32'(in_allowin_o), 32'h1);
    chk("rst_out_data", out_data_o, 32'h0);
    advance();
    rst = 1'b0;

    // ADD imm 5 + regfile 7
    in_valid_i    = 1'b1;
    in_aluOp_i    = 4'd0;
    in_writeNum_i = 5'd3;
    in_pc_i       = 32'h0000_0100;
    in_opIsReg_i  = 2'b10;
    in_preSrc_i   = {32'd0, 32'd5};
    in_readData_i = {32'd7, 32'd0};
    in_fwdSel_i   = {4'b0001, 4'b0000};
    sample();
    advance();

    // Dependent ADD: op0 from own last result, op1 imm 3
    in_pc_i       = 32'h0000_0104;
    in_opIsReg_i  = 2'b01;
    in_preSrc_i   = {32'd3, 32'd0};
    in_readData_i = '0;
    in_fwdSel_i   = {4'b0000, 4'b0010};
    sample();
    chk("add_imm_reg", out_data_o, 32'd12);
    chk("add_imm_reg_valid", 32'(out_valid_o), 32'h1);
    chk("add_imm_reg_pc", out_pc_o, 32'h0000_0100);
    advance();
    in_valid_i = 1'b0;
    sample();
    chk("add_lastres", out_data_o, 32'd15);
    advance();

    // Late bus capture held across a 3-cycle stall
    in_valid_i    = 1'b1;
    out_allowin_i = 1'b0;
    in_opIsReg_i  = 2'b01;
    in_preSrc_i   = '0;
    in_fwdSel_i   = {4'b0000, 4'b0100};
    sample();
    advance();
    in_valid_i = 1'b0;
    lateFwd_i  = {32'h0, 32'h0000_00A5};
    sample();
    chk("late_first", out_data_o, 32'h0000_00A5);
    advance();
    lateFwd_i = {32'hFF, 32'hFF};
    for (int i = 0; i < 3; i++) begin
      sample();
      chk("late_hold", out_data_o, 32'h0000_00A5);
      advance();
    end
    out_allowin_i = 1'b1;
    sample();
    chk("late_release", out_data_o, 32'h0000_00A5);
    advance();

    // Overflow with and without trap
    in_valid_i   = 1'b1;
    in_opIsReg_i = 2'b00;
    in_fwdSel_i  = '0;
    in_preSrc_i  = {32'd1, 32'h7FFF_FFFF};
    in_trapOvf_i = 1'b1;
    sample();
    advance();
    in_trapOvf_i = 1'b0;
    sample();
    chk("ovf_trap", 32'(out_ovf_o), 32'h1);
    chk("ovf_trap_data", out_data_o, 32'h8000_0000);
    advance();
    in_valid_i = 1'b0;
    sample();
    chk("ovf_wrap", 32'(out_ovf_o), 32'h0);
    chk("ovf_wrap_data", out_data_o, 32'h8000_0000);
    advance();

    // Flush beats same-cycle acceptance
    in_valid_i = 1'b1;
    flush_i    = 1'b1;
    sample();
    advance();
    in_valid_i = 1'b0;
    flush_i    = 1'b0;
    sample();
    chk("flush_drop", 32'(out_valid_o), 32'h0);
    advance();

    // Reset pulse during a stall
    in_valid_i    = 1'b1;
    out_allowin_i = 1'b0;
    in_preSrc_i   = {32'd9, 32'd4};
    sample();
    advance();
    in_valid_i = 1'b0;
    sample();
    chk("hold_valid", 32'(out_valid_o), 32'h1);
    chk("hold_data", out_data_o, 32'd13);
    advance();
    rst = 1'b1;
    sample();
    chk("rst_mid_valid", 32'(out_valid_o), 32'h0);
    chk("rst_mid_allowin", 32'(in_allowin_o), 32'h1);
    chk("rst_mid_data", out_data_o, 32'h0);
    advance();
    rst = 1'b0;
    sample();
    chk("post_rst_valid", 32'(out_valid_o), 32'h0);
    advance();

    // Randomized traffic
    for (int c = 0; c < 4000; c++) begin
      rst           = ($urandom_range(0, 399) == 0);
      flush_i       = ($urandom_range(0, 24) == 0);
      in_valid_i    = ($urandom_range(0, 9) < 7);
      out_allowin_i = ($urandom_range(0, 9) < 6);
      in_writeNum_i = 5'($urandom);
      in_pc_i       = 32'($urandom);
      in_notExc_i   = ($urandom_range(0, 4) != 0);
      in_preRes_i   = rval();
      in_aluOp_i    = 4'($urandom);
      in_trapOvf_i  = 1'($urandom);
      in_opIsReg_i  = 2'($urandom);
      in_preSrc_i   = {rval(), rval()};
      in_readData_i = {rval(), rval()};
      in_fwdSel_i   = {rsel(), rsel()};
      lateFwd_i     = {rval(), rval()};
      sample();
      advance();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
